// File: rtl/fifo_pkg.sv
// Shared types for the fifo1 read-side stream adapter.
package fifo_pkg;

  localparam int DSIZE_DEF = 8;

  // Skid-buffer occupancy; the encoding equals the number of held words.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry register skid buffer. slot0 is always the head word and drives
// out_data directly, so the output is registered and holds steady under stall.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic             full
);

  rd_state_t        state_d, state_q;
  logic [DSIZE-1:0] slot0_d, slot0_q;
  logic [DSIZE-1:0] slot1_d, slot1_q;
  logic             take;

  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = slot0_q;
  assign full      = (state_q == S_TWO);
  assign take      = out_valid && out_ready;

  // Occupancy/slot update; flush wins over everything and leaves slots stale.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (push) begin
            slot0_d = push_data;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (push && take) begin
            slot0_d = push_data;
          end else if (push) begin
            slot1_d = push_data;
            state_d = S_TWO;
          end else if (take) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // The top never pushes while full, so only a take can move us.
          if (take) begin
            slot0_d = slot1_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State and slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo1 read-port consumer: pops words whenever the skid buffer has room and
// presents them as a registered valid/ready stream in the rclk domain.
// Optional feature macro: RD_STREAM_CNT_EN adds the rd_cnt delivered-word count.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  input  logic             out_ready
`ifdef RD_STREAM_CNT_EN
  ,
  output logic [31:0]      rd_cnt
`endif
);

  logic full;

  // Pop only when a word exists, the buffer has room and no flush is pending;
  // the reset term keeps rinc low while rrst_n is held.
  assign rinc = rrst_n && !rempty && !flush && !full;

  fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc),
    .push_data (rdata),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (full)
  );

`ifdef RD_STREAM_CNT_EN
  logic        take;
  logic [31:0] rd_cnt_d, rd_cnt_q;

  assign take   = out_valid && out_ready;
  assign rd_cnt = rd_cnt_q;

  // Delivered-word count; wraps naturally and ignores flush.
  always_comb begin
    rd_cnt_d = rd_cnt_q + {31'd0, take};
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rd_cnt_q <= '0;
    else         rd_cnt_q <= rd_cnt_d;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue models fifo1, stimulus pushes
// the expected delivered words, a monitor pops and compares on each take.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
`ifdef RD_STREAM_CNT_EN
  logic [31:0] rd_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DSIZE(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef RD_STREAM_CNT_EN
    ,
    .rd_cnt    (rd_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  task automatic write_word(input logic [7:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // fifo1 model: a word is consumed at the edge where rinc is high.
  always @(posedge rclk) begin
    if (rinc && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
  end

  // Present the new head word away from the sampling edge.
  always @(negedge rclk) refresh();

  // Monitor: inputs settle after the falling edge, so a take seen here
  // happens on the following rising edge.
  always begin
    @(negedge rclk);
    #3;
    if (rrst_n && rinc && rempty) chk("rinc_while_empty", 32'd1, 32'd0);
    if (rrst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_word", {24'd0, out_data}, 32'hFFFF_FFFF);
      else                   chk("stream_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge rclk);
    #5;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin : stim
    logic [7:0] s_words [4];
    int p0;
    int vcnt;
    s_words[0] = 8'h11; s_words[1] = 8'h22; s_words[2] = 8'h33; s_words[3] = 8'h44;

    rrst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fifo_q.delete();
    write_word(8'h77);                 // non-empty FIFO during reset

    // Reset: nothing popped or presented while rrst_n is low.
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk); #1;
      chk("rst_rinc", rinc, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
    end
    fifo_q.delete();                   // fifo1 pointers share the reset
    refresh();
    @(negedge rclk);
    rrst_n = 1'b1;

    // Stream: four words back to back under continuous ready.
    @(negedge rclk);
    out_ready = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      write_word(s_words[i]);
      exp_q.push_back(s_words[i]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk); #1;
      chk("stream_valid", out_valid, 1);
      chk("stream_head", out_data, s_words[i]);
    end
    @(negedge rclk); #1;
    chk("stream_idle", out_valid, 0);
    chk("stream_pops", pop_cnt - p0, 4);

    // Backpressure: only two pops while stalled, head held.
    @(negedge rclk);
    out_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 1; i <= 5; i++) begin
      write_word(8'(i));
      exp_q.push_back(8'(i));
    end
    repeat (4) @(negedge rclk);
    #1;
    chk("bp_pops", pop_cnt - p0, 2);
    chk("bp_rinc", rinc, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 8'h01);
    chk("bp_fifo_left", fifo_q.size(), 3);
    @(negedge rclk); #1;
    chk("bp_hold", out_data, 8'h01);
    out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_pops_total", pop_cnt - p0, 5);

    // Empty boundary: a single word gives one pop and one valid cycle.
    @(negedge rclk);
    p0 = pop_cnt;
    vcnt = 0;
    write_word(8'hA5);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk); #1;
      if (out_valid) vcnt++;
    end
    chk("single_pops", pop_cnt - p0, 1);
    chk("single_valid_cycles", vcnt, 1);
    chk("single_rinc_idle", rinc, 0);

    // Flush while full: buffered pair discarded, FIFO contents untouched.
    @(negedge rclk);
    out_ready = 1'b0;
    p0 = pop_cnt;
    write_word(8'hB1); write_word(8'hB2); write_word(8'hB3);
    write_word(8'hB4); write_word(8'hB5);
    exp_q.push_back(8'hB3); exp_q.push_back(8'hB4); exp_q.push_back(8'hB5);
    repeat (4) @(negedge rclk);
    #1;
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_fifo", fifo_q.size(), 3);
    flush = 1'b1;
    #1;
    chk("fl_rinc", rinc, 0);
    @(negedge rclk);
    flush = 1'b0;
    #1;
    chk("fl_valid", out_valid, 0);
    chk("fl_no_pop", fifo_q.size(), 3);
    out_ready = 1'b1;
    drain("fl_drain");
    chk("fl_pops", pop_cnt - p0, 5);

`ifdef RD_STREAM_CNT_EN
    // 4 + 5 + 1 + 3 takes so far; then preload to all-ones and wrap.
    chk("cnt_total", rd_cnt, 13);
    @(negedge rclk);
    force dut.rd_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt_q;
    chk("cnt_preload", rd_cnt, 32'hFFFF_FFFF);
    write_word(8'h5A);
    exp_q.push_back(8'h5A);
    drain("cnt_drain");
    chk("cnt_wrap", rd_cnt, 0);
`endif

    repeat (2) @(negedge rclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so a stuck DUT still reaches a verdict.
  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
